sqrt_selftest_driver: RTL

//  Synthesizable initiator and checker for the square-root unit (start/clear/num -> result/ready).

---
 rtl/sqrt_selftest_driver_if.sv | 28 ++
 rtl/sqrt_selftest_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sqrt_selftest_driver_if.sv
// Bus between the self-test driver and the square-root unit under test.
// The driver owns start/clear/num; the sqrt unit returns result/ready.
interface sqrt_selftest_driver_if #(
  parameter int NUM_W = 7,
  parameter int RES_W = 4
);
  logic             dut_start;
  logic             dut_clear;
  logic [NUM_W-1:0] dut_num;
  logic [RES_W-1:0] dut_result;
  logic             dut_ready;

  modport master (
    output dut_start,
    output dut_clear,
    output dut_num,
    input  dut_result,
    input  dut_ready
  );

  modport slave (
    input  dut_start,
    input  dut_clear,
    input  dut_num,
    output dut_result,
    output dut_ready
  );
endinterface

// File: rtl/sqrt_selftest_driver.sv
// On-chip self-test driver for a square-root unit.
// Sweeps answers FIRST..LAST, drives num = answer*answer, waits for a rising
// edge on ready and compares the result against the answer. Collects a
// saturating error count, the first failing answer, a sticky timeout flag and
// a pass flag that is valid while done is high.
// Optional build macro: SQRT_SELFTEST_STOP_ON_FAIL_EN -- when defined, the
// first mismatch or timeout ends the sweep immediately.
module sqrt_selftest_driver #(
  parameter int NUM_W   = 7,
  parameter int RES_W   = 4,
  parameter int FIRST   = 1,
  parameter int LAST    = 11,
  parameter int TIMEOUT = 64,
  parameter int ERR_W   = 4
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic                      go,
  sqrt_selftest_driver_if.master    sqrt_bus,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic [RES_W-1:0]          fail_answer,
  output logic                      timeout
);

  // Wide enough to hold TIMEOUT-1 for any TIMEOUT >= 1.
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  // Parameter sanity: the largest operand must fit in dut_num, the sweep
  // range must be ordered and every answer must fit in the result width.
  if (LAST * LAST > (2 ** NUM_W) - 1) begin : g_chk_num_w
    $error("sqrt_selftest_driver: LAST*LAST does not fit in NUM_W bits");
  end
  if (FIRST > LAST) begin : g_chk_range
    $error("sqrt_selftest_driver: FIRST must not exceed LAST");
  end
  if (LAST >= 2 ** RES_W) begin : g_chk_res_w
    $error("sqrt_selftest_driver: LAST does not fit in RES_W bits");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q,       state_d;
  logic [RES_W-1:0] answer_q,      answer_d;
  logic [TMR_W-1:0] timer_q,       timer_d;
  logic [NUM_W-1:0] dut_num_q,     dut_num_d;
  logic [ERR_W-1:0] err_count_q,   err_count_d;
  logic [RES_W-1:0] fail_answer_q, fail_answer_d;
  logic             timeout_q,     timeout_d;
  logic             done_q,        done_d;
  logic             pass_q,        pass_d;
  logic             ready_q;

  logic             ready_rise;
  logic             test_end;
  logic             test_fail;
  logic             sweep_stop;
  logic [RES_W-1:0] answer_inc;

  // Operand for a given answer; the parameter checks guarantee no overflow.
  function automatic logic [NUM_W-1:0] square(input logic [RES_W-1:0] a);
    logic [2*RES_W-1:0] a_ext;
    logic [2*RES_W-1:0] prod;
    a_ext = {{RES_W{1'b0}}, a};
    prod  = a_ext * a_ext;
    return NUM_W'(prod);
  endfunction

  // Only a 0->1 edge of ready marks a valid result; a ready that is already
  // high when RUN starts is filtered out because ready_q tracks it in CLR.
  assign ready_rise = sqrt_bus.dut_ready & ~ready_q;
  assign answer_inc = answer_q + 1'b1;

  // State register and all sweep bookkeeping, cleared asynchronously.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q       <= S_IDLE;
      answer_q      <= '0;
      timer_q       <= '0;
      dut_num_q     <= '0;
      err_count_q   <= '0;
      fail_answer_q <= '0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      answer_q      <= answer_d;
      timer_q       <= timer_d;
      dut_num_q     <= dut_num_d;
      err_count_q   <= err_count_d;
      fail_answer_q <= fail_answer_d;
      timeout_q     <= timeout_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      ready_q       <= sqrt_bus.dut_ready;
    end
  end

  // Next-state logic: start a sweep on go, one CLR cycle per test, then RUN
  // until a ready rise or timeout, scoring the test and advancing.
  always_comb begin
    state_d       = state_q;
    answer_d      = answer_q;
    timer_d       = timer_q;
    dut_num_d     = dut_num_q;
    err_count_d   = err_count_q;
    fail_answer_d = fail_answer_q;
    timeout_d     = timeout_q;
    done_d        = done_q;
    pass_d        = pass_q;
    test_end      = 1'b0;
    test_fail     = 1'b0;
    sweep_stop    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (go) begin
          err_count_d   = '0;
          fail_answer_d = '0;
          timeout_d     = 1'b0;
          done_d        = 1'b0;
          pass_d        = 1'b0;
          answer_d      = RES_W'(FIRST);
          dut_num_d     = square(RES_W'(FIRST));
          state_d       = S_CLR;
        end
      end

      S_CLR: begin
        timer_d = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        timer_d = timer_q + 1'b1;
        // A rise in the final timer cycle still counts as a normal answer.
        if (ready_rise) begin
          test_end  = 1'b1;
          test_fail = (sqrt_bus.dut_result != answer_q);
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          test_end  = 1'b1;
          test_fail = 1'b1;
          timeout_d = 1'b1;
        end

        if (test_fail) begin
          if (err_count_q != {ERR_W{1'b1}}) begin
            err_count_d = err_count_q + 1'b1;
          end
          if (fail_answer_q == '0) begin
            fail_answer_d = answer_q;
          end
        end

        if (test_end) begin
          sweep_stop = (answer_q == RES_W'(LAST));
`ifdef SQRT_SELFTEST_STOP_ON_FAIL_EN
          sweep_stop = sweep_stop | test_fail;
`endif
          if (sweep_stop) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            pass_d  = (err_count_d == '0) && !timeout_d;
          end else begin
            answer_d  = answer_inc;
            dut_num_d = square(answer_inc);
            state_d   = S_CLR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The sqrt unit is held in clear everywhere except RUN, where start is high.
  assign sqrt_bus.dut_start = (state_q == S_RUN);
  assign sqrt_bus.dut_clear = (state_q != S_RUN);
  assign sqrt_bus.dut_num   = dut_num_q;

  assign busy        = (state_q == S_CLR) || (state_q == S_RUN);
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_count   = err_count_q;
  assign fail_answer = fail_answer_q;
  assign timeout     = timeout_q;

endmodule
